// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU M stage
// and an external host port. The CPU wins by default, and a bounded-wait
// counter forces the host ahead after HOST_MAX_WAIT denied cycles. The cycle
// after any host grant always serves the CPU.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   cpu_opcode/addr/wdata        M-stage request (lw = 01000, sw = 00111)
//   cpu_stall                    combinational stall when the CPU loses the port
//   cpu_rdata                    load data (mem_q, valid the cycle after a lw)
//   host_req/we/addr/wdata       host request, held until acknowledged
//   host_ack, host_rdata         completion pulse and registered read data
//   mem_addr/wdata/wren, mem_q   memory port (1-cycle registered read)
module dmem_arbiter #(
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        cpu_opcode,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned    CNT_W    = 4;
    localparam logic [4:0]     OP_LW    = 5'b01000;
    localparam logic [4:0]     OP_SW    = 5'b00111;
    localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(HOST_MAX_WAIT);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_HOST_ACK = 1'b1
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                host_rd_q;      // granted host transaction was a read
    logic [DATA_W-1:0]   host_rdata_q;

    logic cpu_rd;
    logic cpu_wr;
    logic cpu_req;
    logic host_gnt;

    // Upper ALU-result bits are not part of the data-memory word address.
    logic unused_cpu_addr_hi;
    assign unused_cpu_addr_hi = ^cpu_addr[31:ADDR_W];

    // M-stage opcode decode.
    always_comb begin
        cpu_rd  = (cpu_opcode == OP_LW);
        cpu_wr  = (cpu_opcode == OP_SW);
        cpu_req = cpu_rd | cpu_wr;
    end

    // Host grant: only from IDLE, when the CPU is quiet or the host has waited long enough.
    always_comb begin
        host_gnt = 1'b0;
        if (!reset && (state_q == S_IDLE)) begin
            host_gnt = host_req && (!cpu_req || (wait_cnt_q == MAX_WAIT));
        end
    end

    // Memory port mux; the CPU owns the port whenever the host is not granted.
    always_comb begin
        mem_addr  = cpu_addr[ADDR_W-1:0];
        mem_wdata = cpu_wdata;
        mem_wren  = cpu_wr && !reset;
        cpu_stall = host_gnt && cpu_req;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wren  = host_we;
        end
    end

    // Arbitration FSM, wait counter and host read-data capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            host_rd_q    <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host_gnt) begin
                        state_q    <= S_HOST_ACK;
                        wait_cnt_q <= '0;
                        host_rd_q  <= !host_we;
                    end else if (!host_req) begin
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q != MAX_WAIT) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_HOST_ACK: begin
                    state_q    <= S_IDLE;
                    wait_cnt_q <= '0;
                    // mem_q now holds the word read in the grant cycle.
                    if (host_rd_q) begin
                        host_rdata_q <= mem_q;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    // A reset landing on the ack cycle suppresses the ack.
    assign host_ack   = (state_q == S_HOST_ACK) && !reset;
    assign host_rdata = host_rdata_q;
    assign cpu_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// CPU/host traffic, all compared against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned MAXW  = 4;
    localparam int unsigned MEM_N = 1 << AW;
    localparam logic [4:0]  OP_LW = 5'b01000;
    localparam logic [4:0]  OP_SW = 5'b00111;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    cpu_opcode;
    logic [31:0]   cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .cpu_opcode(cpu_opcode), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Single-port memory with registered read; cleared while reset is high.
    logic [DW-1:0] mem [0:MEM_N-1];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
            mem_q <= '0;
        end else begin
            if (mem_wren) mem[mem_addr] <= mem_wdata;
            mem_q <= mem[mem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the port this cycle and what the host sees.
    bit            m_ack;        // this cycle is the ack cycle of a host grant
    int            m_wait;       // consecutive denied host cycles
    logic [DW-1:0] m_rdata;      // expected host_rdata
    bit            m_pend_rd;
    logic [DW-1:0] m_pend_val;
    bit            m_lw_chk;
    logic [DW-1:0] m_lw_val;
    logic [DW-1:0] ref_mem [0:MEM_N-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle against the model (called at negedge with inputs set), then advance it.
    task automatic cycle();
        bit            c_rd, c_wr, c_req, hg;
        logic          e_wren;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        #1;
        c_rd  = (cpu_opcode == OP_LW);
        c_wr  = (cpu_opcode == OP_SW);
        c_req = c_rd || c_wr;
        hg    = !reset && !m_ack && host_req && (!c_req || m_wait >= int'(MAXW));
        e_wren  = hg ? host_we    : c_wr;
        e_addr  = hg ? host_addr  : cpu_addr[AW-1:0];
        e_wdata = hg ? host_wdata : cpu_wdata;
        chk("host_rdata", 64'(host_rdata), 64'(m_rdata));
        if (reset) begin
            chk("rst_stall", 64'(cpu_stall), 64'(0));
            chk("rst_wren", 64'(mem_wren), 64'(0));
            chk("rst_ack", 64'(host_ack), 64'(0));
        end else begin
            chk("cpu_stall", 64'(cpu_stall), 64'(hg && c_req));
            chk("mem_wren", 64'(mem_wren), 64'(e_wren));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            if (e_wren) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            chk("host_ack", 64'(host_ack), 64'(m_ack));
            if (m_lw_chk) chk("cpu_rdata", 64'(cpu_rdata), 64'(m_lw_val));
        end
        @(posedge clock);
        if (reset) begin
            m_ack = 0; m_wait = 0; m_rdata = '0; m_lw_chk = 0; m_pend_rd = 0;
            for (int i = 0; i < MEM_N; i++) ref_mem[i] = '0;
        end else begin
            if (m_ack && m_pend_rd) m_rdata = m_pend_val;
            m_lw_chk = !hg && c_rd;
            m_lw_val = ref_mem[cpu_addr[AW-1:0]];
            if (hg) begin
                m_pend_rd  = !host_we;
                m_pend_val = ref_mem[host_addr];
            end
            if (e_wren) ref_mem[e_addr] = e_wdata;
            if (!host_req || hg || m_ack) m_wait = 0;
            else if (m_wait < int'(MAXW)) m_wait++;
            m_ack = hg;
        end
        @(negedge clock);
    endtask

    task automatic host_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = req; host_we = we; host_addr = a; host_wdata = d;
    endtask

    task automatic cpu_set(input logic [4:0] op, input logic [31:0] a, input logic [DW-1:0] d);
        cpu_opcode = op; cpu_addr = a; cpu_wdata = d;
    endtask

    initial begin
        bit busy;
        bit was_ack;
        logic [4:0] ops [3];
        ops[0] = 5'b00001; ops[1] = 5'b11000; ops[2] = 5'b10100;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = '0;
        m_ack = 0; m_wait = 0; m_rdata = '0; m_pend_rd = 0; m_pend_val = '0;
        m_lw_chk = 0; m_lw_val = '0;
        reset = 1'b1;
        cpu_set(5'b0, 32'h0, '0);
        host_set(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b0;

        // Uncontended host write then read of 0x010.
        host_set(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        #1 chk("t1_wr_wren", 64'(mem_wren), 64'(1));
        cycle();
        host_set(1'b0, 1'b0, 12'h000, '0);
        #1 chk("t1_wr_ack", 64'(host_ack), 64'(1));
        cycle();
        host_set(1'b1, 1'b0, 12'h010, '0);
        cycle();
        host_set(1'b0, 1'b0, 12'h000, '0);
        #1 chk("t1_rd_ack", 64'(host_ack), 64'(1));
        cycle();
        #1 chk("t1_rdata", 64'(host_rdata), 64'(32'hDEADBEEF));
        cycle();

        // CPU priority: continuous sw vs pending host write.
        cpu_set(OP_SW, 32'hABC0_0030, 32'h1111_1111);
        host_set(1'b1, 1'b1, 12'h040, 32'h2222_2222);
        for (int k = 0; k < int'(MAXW); k++) begin
            #1 chk("t2_denied_stall", 64'(cpu_stall), 64'(0));
            chk("t2_denied_addr", 64'(mem_addr), 64'(12'h030));
            cycle();
        end
        #1 chk("t2_gnt_stall", 64'(cpu_stall), 64'(1));
        chk("t2_gnt_addr", 64'(mem_addr), 64'(12'h040));
        cycle();
        host_set(1'b0, 1'b0, 12'h000, '0);
        #1 chk("t2_ack_stall", 64'(cpu_stall), 64'(0));
        chk("t2_ack_cpu_sw", 64'(mem_wren), 64'(1));
        chk("t2_ack_addr", 64'(mem_addr), 64'(12'h030));
        cycle();

        // CPU-only traffic: sw/lw to 0x020.
        for (int k = 0; k < 3; k++) begin
            cpu_set(OP_SW, 32'h0000_0020, 32'hCAFE_0000 + 32'(k));
            cycle();
            cpu_set(OP_LW, 32'h0000_0020, '0);
            #1 chk("t3_lw_wren", 64'(mem_wren), 64'(0));
            cycle();
            cpu_set(5'b0, 32'h0, '0);
            #1 chk("t3_lw_rdata", 64'(cpu_rdata), 64'(32'hCAFE_0000 + 32'(k)));
            cycle();
        end

        // Back-to-back host requests with the CPU idle.
        host_set(1'b1, 1'b1, 12'h050, 32'h5555_AAAA);
        for (int k = 0; k < 6; k++) begin
            #1 chk("t4_ack", 64'(host_ack), 64'(k % 2));
            chk("t4_wren", 64'(mem_wren), 64'(1 - (k % 2)));
            cycle();
        end
        host_set(1'b0, 1'b0, 12'h000, '0);
        cycle();

        // Reset in the ack cycle.
        host_set(1'b1, 1'b0, 12'h010, '0);
        cycle();
        reset = 1'b1;
        #1 chk("t5_rst_ack", 64'(host_ack), 64'(0));
        cycle();
        reset = 1'b0;
        host_set(1'b1, 1'b1, 12'h060, 32'h6666_6666);
        #1 chk("t5_rdata_clr", 64'(host_rdata), 64'(0));
        chk("t5_regrant", 64'(mem_wren), 64'(1));
        cycle();
        host_set(1'b0, 1'b0, 12'h000, '0);
        cycle();

        // Non-memory opcodes do not block the host.
        for (int k = 0; k < 3; k++) begin
            cpu_set(ops[k], 32'h0000_0070, 32'h7);
            host_set(1'b1, 1'b1, 12'h080 + 12'(k), 32'h8888_0000 + 32'(k));
            #1 chk("t6_stall", 64'(cpu_stall), 64'(0));
            chk("t6_gnt", 64'(mem_addr), 64'(12'h080 + 12'(k)));
            cycle();
            host_set(1'b0, 1'b0, 12'h000, '0);
            cycle();
        end

        // Random traffic; host holds its request until the model's ack cycle.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        busy = 0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: cpu_opcode = OP_LW;
                1: cpu_opcode = OP_SW;
                2: cpu_opcode = 5'($urandom);
                default: cpu_opcode = 5'b0;
            endcase
            cpu_addr  = $urandom;
            cpu_addr[AW-1:0] = AW'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            if (!busy) begin
                host_set(1'($urandom_range(0, 1)), 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
                busy = host_req;
            end
            reset = ($urandom_range(0, 99) == 0);
            was_ack = m_ack;
            cycle();
            if (was_ack || reset) busy = 0;
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
